// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: a chain of DEPTH elastic register stages, WIDTH bits each,
// with a valid/ready handshake. Words advance into empty slots (bubble
// collapsing) and stall under back-pressure without loss. Provides a
// synchronous flush and a registered occupancy count.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   flush      synchronous clear of all valid bits (data untouched)
//   in_valid   in_data is presented
//   in_ready   chain accepts in_data this cycle (combinational via advance chain)
//   in_data    input word
//   out_valid  stage DEPTH-1 holds a word
//   out_ready  consumer takes out_data this cycle
//   out_data   word in stage DEPTH-1
//   count      number of valid stages

// Occupancy checker: the registered count must track the valid bits.
module pipe_reg_chain_chk #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input logic             clk,
  input logic             reset,
  input logic [DEPTH-1:0] v,
  input logic [CW-1:0]    count
);

  // count equals popcount of the valid bits after every edge
  a_count_popcount: assert property (@(posedge clk) disable iff (!reset)
    count == CW'($countones(v)));

endmodule

module pipe_reg_chain #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [CW-1:0]    r_count;

  logic [DEPTH-1:0] w_adv;
  logic             w_in_xfer;
  logic             w_out_xfer;

  // Advance terms. adv[i] = out_ready | (some stage j >= i is empty); written
  // in closed form so no bit of w_adv depends on another bit of w_adv.
  always_comb begin
    w_adv = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      w_adv[i] = out_ready | ~(&(r_v | ((DEPTH'(1) << i) - DEPTH'(1))));
    end
  end

  // in_ready is forced low during reset and during a flush cycle
  assign in_ready   = w_adv[0] & ~flush & reset;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = r_v[DEPTH-1] & out_ready;

  assign out_valid = r_v[DEPTH-1];
  assign out_data  = r_d[DEPTH-1];
  assign count     = r_count;

  // Stage registers and occupancy count; flush clears valids only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v     <= {DEPTH{1'b0}};
      r_count <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= RESET_VAL;
      end
    end else if (flush) begin
      r_v     <= {DEPTH{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_adv[0]) begin
        r_v[0] <= in_valid;
        if (in_valid) begin
          r_d[0] <= in_data;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_adv[i]) begin
          r_v[i] <= r_v[i-1];
          // data under an invalid source is left alone
          if (r_v[i-1]) begin
            r_d[i] <= r_d[i-1];
          end
        end
      end
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  pipe_reg_chain_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk   (clk),
    .reset (reset),
    .v     (r_v),
    .count (r_count)
  );

endmodule

// File: tb/tb_pipe_reg_chain.sv
module tb_pipe_reg_chain;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [2:0] count;

  logic       flush1, in_valid1, out_ready1;
  logic [7:0] in_data1;
  logic       in_ready1, out_valid1;
  logic [7:0] out_data1;
  logic [0:0] count1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_reg_chain #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  pipe_reg_chain #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .count(count1)
  );

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       fl;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t tbl1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(input int sel, input logic iv, input logic [7:0] d,
                              input logic ordy, input logic fl, input logic e_ir,
                              input logic e_ov, input logic [7:0] e_od,
                              input logic [2:0] e_cnt);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
    if (sel == 0) tbl.push_back(v);
    else          tbl1.push_back(v);
  endfunction

  // Drive one vector at the falling edge, compare 1 ns later; the following
  // rising edge then commits it. Outputs seen reflect state before that edge.
  task automatic apply(input int sel, input vec_t v, input int k);
    @(negedge clk);
    if (sel == 0) begin
      in_valid = v.iv; in_data = v.d; out_ready = v.ordy; flush = v.fl;
    end else begin
      in_valid1 = v.iv; in_data1 = v.d; out_ready1 = v.ordy; flush1 = v.fl;
    end
    #1;
    if (sel == 0) begin
      chk($sformatf("d4_v%0d_in_ready", k), {31'd0, in_ready}, {31'd0, v.e_ir});
      chk($sformatf("d4_v%0d_out_valid", k), {31'd0, out_valid}, {31'd0, v.e_ov});
      chk($sformatf("d4_v%0d_count", k), {29'd0, count}, {29'd0, v.e_cnt});
      if (v.e_ov) chk($sformatf("d4_v%0d_out_data", k), {24'd0, out_data}, {24'd0, v.e_od});
    end else begin
      chk($sformatf("d1_v%0d_in_ready", k), {31'd0, in_ready1}, {31'd0, v.e_ir});
      chk($sformatf("d1_v%0d_out_valid", k), {31'd0, out_valid1}, {31'd0, v.e_ov});
      chk($sformatf("d1_v%0d_count", k), {31'd0, count1}, {29'd0, v.e_cnt});
      if (v.e_ov) chk($sformatf("d1_v%0d_out_data", k), {24'd0, out_data1}, {24'd0, v.e_od});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // latency: 11, bubble, 22 with out_ready=1
    add(0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    add(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1);
    add(0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1);
    add(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd2);
    add(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 3'd2);
    add(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1);
    add(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 3'd1);
    add(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    // back-pressure: 01..06, out_ready low until the chain is full
    add(0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    add(0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1);
    add(0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd2);
    add(0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd3);
    add(0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4);
    add(0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4);
    add(0, 1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 3'd4);
    add(0, 1'b1, 8'h06, 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 3'd4);
    add(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 3'd4);
    add(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h04, 3'd3);
    add(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 3'd2);
    add(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h06, 3'd1);
    add(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    // flush at count=3 with 77 presented
    add(0, 1'b1, 8'h31, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    add(0, 1'b1, 8'h32, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1);
    add(0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd2);
    add(0, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd3);
    add(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    add(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    add(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    // flush on a full chain while the consumer takes the head word
    add(0, 1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    add(0, 1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1);
    add(0, 1'b1, 8'h43, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd2);
    add(0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd3);
    add(0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h41, 3'd4);
    add(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    // DEPTH=1: single elastic register, in_ready = out_ready | ~v
    add(1, 1'b1, 8'hC1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    add(1, 1'b1, 8'hC2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC1, 3'd1);
    add(1, 1'b1, 8'hC2, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC1, 3'd1);
    add(1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC2, 3'd1);
    add(1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);

    // reset held with traffic presented
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
    flush1 = 1'b0; in_valid1 = 1'b0; in_data1 = 8'h00; out_ready1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {24'd0, out_data}, 32'h00);
      chk("rst_count", {29'd0, count}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1 chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    for (int k = 0; k < tbl.size(); k++) apply(0, tbl[k], k);

    // full pass-through: fill A0..A3, then 8 cycles in and out together
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hA0 + 8'(k); out_ready = 1'b0; flush = 1'b0;
      #1 chk("fill_count", {29'd0, count}, k);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hA4 + 8'(k); out_ready = 1'b1;
      #1;
      chk("pass_in_ready", {31'd0, in_ready}, 32'd1);
      chk("pass_count", {29'd0, count}, 32'd4);
      chk("pass_out_valid", {31'd0, out_valid}, 32'd1);
      chk("pass_out_data", {24'd0, out_data}, 32'hA0 + k);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      chk("drain_out_valid", {31'd0, out_valid}, 32'd1);
      chk("drain_out_data", {24'd0, out_data}, 32'hA8 + k);
      chk("drain_count", {29'd0, count}, 4 - k);
    end
    @(negedge clk); #1;
    chk("drain_empty", {31'd0, out_valid}, 32'd0);

    // reset between edges with count=2; last stage still holds AB
    @(negedge clk); in_valid = 1'b1; in_data = 8'h51; out_ready = 1'b0;
    @(negedge clk); in_data = 8'h52;
    @(negedge clk); in_valid = 1'b0;
    #1 chk("mid_count_pre", {29'd0, count}, 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_out_data", {24'd0, out_data}, 32'h00);
    chk("mid_count", {29'd0, count}, 32'd0);
    chk("mid_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    #1 reset = 1'b1;
    #1 chk("mid_rel_in_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("mid_no_stale_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_no_stale_count", {29'd0, count}, 32'd0);
    end

    for (int k = 0; k < tbl1.size(); k++) apply(1, tbl1[k], k);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised successor of the team's plain D register: a chain of DEPTH elastic register stages, each WIDTH bits wide, with a valid/ready handshake.
- Each stage holds a data word plus a valid bit. The chain advances into empty slots (bubble collapsing) and stalls under back-pressure without losing data.
- A synchronous flush and an occupancy count are provided.
- Used between state-machine datapaths and slower consumers, and as a configurable-latency delay line.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 4, number of register stages (>=1).
- RESET_VAL, 0, value loaded into every stage data register on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- flush  input  1  synchronous clear of all valid bits.
- in_valid  input  1  in_data is presented.
- in_ready  output  1  chain accepts in_data this cycle.
- in_data  input  WIDTH  input word.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  consumer takes out_data this cycle.
- out_data  output  WIDTH  word in stage DEPTH-1.
- count  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is asynchronous and active-low.
  - While reset=0: every v[i]=0, every d[i]=RESET_VAL, out_valid=0, out_data=RESET_VAL, count=0, in_ready=0.
  - Reset may be asserted at any time, including mid-transfer; in-flight words are discarded.
  - After release, in_ready=1 from the first cycle (the chain is empty).
- Stage state: stages 0..DEPTH-1, each with d[i] (WIDTH bits) and v[i] (1 bit). Stage 0 is the input end; stage DEPTH-1 is the output end.
- Advance terms (combinational):
  - adv[DEPTH-1] = out_ready | ~v[DEPTH-1].
  - adv[i] = adv[i+1] | ~v[i] for i < DEPTH-1.
- Handshake:
  - in_ready = adv[0] & ~flush.
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - out_valid = v[DEPTH-1]; out_data = d[DEPTH-1].
  - in_ready depends combinationally on out_ready through the adv chain. This is intended; no skid buffer.
- Stage update on each rising edge, when flush=0 and adv[i]=1:
  - Stage 0: v[0] <= in_valid. If in_valid, d[0] <= in_data.
  - Stage i>0: v[i] <= v[i-1]. If v[i-1], d[i] <= d[i-1].
  - When adv[i]=0 the stage holds both v[i] and d[i].
  - When the source is invalid, d[i] keeps its old value. Data under v=0 is don't-care but must not be X after reset.
- Latency and throughput:
  - In an empty chain with out_ready=1, a word accepted at edge N is visible at out_valid/out_data after edge N+DEPTH-1, i.e. DEPTH cycles after presentation.
  - Throughput is 1 word/cycle when out_ready=1.
- Back-pressure:
  - With out_ready=0 the chain fills. After DEPTH accepted words, in_ready=0 and count=DEPTH.
  - Order is preserved; no drop, no duplicate.
- Flush (synchronous, priority over all updates):
  - On an edge with flush=1, all v[i] <= 0 and data is not modified.
  - in_ready=0 during the flush cycle, so no input is accepted.
  - out_valid keeps its pre-edge value during the flush cycle. An output transfer during that cycle is considered completed; the word is not re-presented.
- Simultaneous events:
  - Full chain with in_valid=1 and out_ready=1: in_ready=1; one word leaves and one enters on the same edge; count is unchanged.
  - Flush together with reset: reset wins.
- count:
  - Registered; equals the popcount of v[] after each edge.
  - count = 0 after reset or flush.
  - Update rule: +1 on input transfer, −1 on output transfer, unchanged when both or neither occur; forced to 0 on flush.
  - Must always equal the popcount of v[] (assertion).
- Width rules: no arithmetic on data. count width is $clog2(DEPTH+1); for DEPTH=1 it is 1 bit.
- DEPTH=1 degenerates to a single elastic register: in_ready = out_ready | ~v[0].

Test Plan:
- Reset/idle:
  - Stimulus: hold reset=0 for 3 cycles with in_valid=1, in_data=8'hAA.
  - Required: out_valid=0, out_data=8'h00, count=0, in_ready=0.
  - After release: in_ready=1 on the first cycle.
- Latency (WIDTH=8, DEPTH=4, out_ready=1):
  - Stimulus: push 8'h11 at cycle 0, bubble at cycle 1, 8'h22 at cycle 2.
  - Required: out_valid=1 with 8'h11 at cycle 4, out_valid=0 at cycle 5, 8'h22 at cycle 6.
- Back-pressure:
  - Stimulus: out_ready=0; push 8'h01..8'h06 continuously.
  - Required: words 01..04 accepted, in_ready=0 from cycle 4, count=4.
  - Then raise out_ready: outputs 01,02,03,04,05,06 in order; count returns to 0.
- Full pass-through:
  - Stimulus: chain full, in_valid=1, out_ready=1 for 8 cycles.
  - Required: in_ready=1 every cycle, count stays 4, one word out per cycle.
- Flush:
  - Stimulus: with count=3, assert flush=1 for one cycle with in_valid=1, in_data=8'h77.
  - Required: in_ready=0 during flush; count=0 and out_valid=0 next cycle; 8'h77 never appears at the output.
- Reset mid-operation:
  - Stimulus: assert reset=0 asynchronously between edges with count=2.
  - Required: out_valid=0, out_data=8'h00, count=0 immediately (before the next edge).
  - Required: no stale word appears after release.
